// File: rtl/alu_serial_seq.sv
// Bit-serial AND/OR/ADD/SUB/SLT sequencer: one bit per clock, LSB first, start/busy/done handshake.
// Optional zero flag port and accumulator enabled by defining ALU_SERIAL_ZERO_EN.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             binv,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef ALU_SERIAL_ZERO_EN
    output logic             cout,
    output logic             zero
`else
    output logic             cout
`endif
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [IW-1:0]    idx;
    logic [1:0]       op_r;
    logic             inv_r;
    logic             carry;

    logic             abit;
    logic             nb;
    logic             sum;
    logic             cnext;
    logic             rbit;
    logic             less;
    logic [WIDTH-1:0] final_res;
    logic             final_cout;

    // Single-bit slice; the final word is assembled with the current bit so that
    // result/cout can be registered on the same edge that enters DONE.
    always_comb begin
        abit  = a_sr[0];
        nb    = b_sr[0] ^ inv_r;
        sum   = abit ^ nb ^ carry;
        cnext = (abit & nb) | (abit & carry) | (nb & carry);
        case (op_r)
            2'b00:   rbit = abit & nb;
            2'b01:   rbit = abit | nb;
            default: rbit = sum;
        endcase
        less       = sum ^ (carry ^ cnext);
        final_res  = {rbit, res_sr[WIDTH-1:1]};
        if (op_r == 2'b11) begin
            final_res    = '0;
            final_res[0] = less;
        end
        final_cout = op_r[1] ? cnext : 1'b0;
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            idx    <= '0;
            op_r   <= '0;
            inv_r  <= 1'b0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= opA;
                        b_sr  <= opB;
                        op_r  <= op;
                        inv_r <= binv | (op == 2'b11);
                        carry <= binv | (op == 2'b11);
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= final_res;
                    carry  <= cnext;
                    res_sr <= {rbit, res_sr[WIDTH-1:1]};
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        result <= final_res;
                        cout   <= final_cout;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SERIAL_ZERO_EN
    logic zacc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zacc <= 1'b0;
            zero <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                zacc <= 1'b0;
            end else if (state == S_RUN) begin
                zacc <= zacc | rbit;
                if (idx == LAST) begin
                    zero <= (op_r == 2'b11) ? ~less : ~(zacc | rbit);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed, table-driven bench for alu_serial_seq (WIDTH=8), plus hand-written
// sequences for back-to-back start and asynchronous reset mid-operation.
module tb_alu_serial_seq;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic         binv;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef ALU_SERIAL_ZERO_EN
    logic         zero;
`endif

    int compared   = 0;
    int mismatched = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .binv   (binv),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .result (result),
`ifdef ALU_SERIAL_ZERO_EN
        .cout   (cout),
        .zero   (zero)
`else
        .cout   (cout)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   op;
        logic         binv;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cout;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a clock edge with the DUT idle; returns #1 after the edge that leaves DONE.
    task automatic run_op(input string tag, input logic [1:0] o, input logic bi,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec);
        logic window_ok;
        op    = o;
        binv  = bi;
        opA   = a;
        opB   = b;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        opA   = ~a;
        opB   = ~b;
        op    = ~o;
        binv  = ~bi;
        window_ok = (busy === 1'b1) && (done === 1'b0);
        for (int i = 1; i < W; i++) begin
            @(posedge clock); #1;
            if (!((busy === 1'b1) && (done === 1'b0))) window_ok = 1'b0;
        end
        check({tag, " busy_window"}, 32'(window_ok), 32'd1);
        @(posedge clock); #1;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_off"}, 32'(busy), 32'd0);
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef ALU_SERIAL_ZERO_EN
        check({tag, " zero"}, 32'(zero), 32'(er == '0));
`endif
        @(posedge clock); #1;
        check({tag, " done_clear"}, 32'(done), 32'd0);
        check({tag, " result_held"}, 32'(result), 32'(er));
    endtask

    initial begin
        int pulses;
        vecs[0]  = '{2'b10, 1'b0, 8'h5A, 8'h27, 8'h81, 1'b0};
        vecs[1]  = '{2'b10, 1'b1, 8'h10, 8'h01, 8'h0F, 1'b1};
        vecs[2]  = '{2'b00, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[3]  = '{2'b01, 1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0};
        vecs[4]  = '{2'b00, 1'b1, 8'hF0, 8'h3C, 8'hC0, 1'b0};
        vecs[5]  = '{2'b11, 1'b0, 8'h80, 8'h01, 8'h01, 1'b1};
        vecs[6]  = '{2'b11, 1'b0, 8'h7F, 8'h80, 8'h00, 1'b0};
        vecs[7]  = '{2'b11, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1};
        vecs[8]  = '{2'b11, 1'b1, 8'h01, 8'h80, 8'h00, 1'b0};
        vecs[9]  = '{2'b10, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[10] = '{2'b10, 1'b1, 8'h33, 8'h33, 8'h00, 1'b1};
        vecs[11] = '{2'b10, 1'b1, 8'h34, 8'h33, 8'h01, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        binv  = 1'b0;
        opA   = '0;
        opB   = '0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
`ifdef ALU_SERIAL_ZERO_EN
        check("reset zero", 32'(zero), 32'd0);
`endif
        #11 reset = 1'b0;
        @(posedge clock); #1;

        for (int v = 0; v < 12; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].binv, vecs[v].a, vecs[v].b,
                   vecs[v].res, vecs[v].cout);
        end

        // start held high: only E0 and E10 operands accepted
        op = 2'b10; binv = 1'b0; opA = 8'h12; opB = 8'h34; start = 1'b1;
        @(posedge clock); #1;
        pulses = 0;
        for (int k = 1; k <= 19; k++) begin
            if (k == 10) begin
                op = 2'b10; binv = 1'b1; opA = 8'h50; opB = 8'h20;
            end else begin
                op = 2'(k); binv = k[0]; opA = 8'(k * 13); opB = 8'(k * 7 + 1);
            end
            @(posedge clock); #1;
            if (done === 1'b1) pulses++;
            if (k == 8) begin
                check("hold first done", 32'(done), 32'd1);
                check("hold first result", 32'(result), 32'h46);
                check("hold first cout", 32'(cout), 32'd0);
            end
            if (k == 9) check("hold idle gap busy", 32'(busy), 32'd0);
            if (k == 10) check("hold second accepted", 32'(busy), 32'd1);
            if (k == 18) begin
                check("hold second done", 32'(done), 32'd1);
                check("hold second result", 32'(result), 32'h30);
                check("hold second cout", 32'(cout), 32'd1);
            end
        end
        start = 1'b0;
        check("hold done pulses", 32'(pulses), 32'd2);
        repeat (10) @(posedge clock);
        #1;

        // Leave a nonzero result so the reset clear is observable
        run_op("pre_reset", 2'b10, 1'b1, 8'h10, 8'h01, 8'h0F, 1'b1);
        op = 2'b10; binv = 1'b0; opA = 8'hFF; opB = 8'h01; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async busy", 32'(busy), 32'd0);
        check("async done", 32'(done), 32'd0);
        check("async result", 32'(result), 32'd0);
        check("async cout", 32'(cout), 32'd0);
`ifdef ALU_SERIAL_ZERO_EN
        check("async zero", 32'(zero), 32'd0);
`endif
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock); #1;
        check("post_reset idle", 32'(busy), 32'd0);
        run_op("post_reset", 2'b10, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
